lcd_bus_driver: RTL and testbench
=================================

# lcd_bus_driver

Low-level HD44780-style parallel bus engine directly downstream of the LCD command controller. It runs the mandatory power-on initialisation sequence itself. It then accepts one byte at a time (command or character) over a ready/busy handshake and generates the RS/D/E bus waveform. It holds `busy_flag` high for the full execution time of each instruction, so the controller never needs to poll the display.

## Interface
Parameters (defaults are cycle counts for a 48 MHz clock):
- `SETUP_CYC`, 4: cycles RS/D are stable before E rises (≥40 ns).
- `EPW_CYC`, 16: cycles E is high (≥230 ns).
- `HOLD_CYC`, 4: cycles RS/D are held after E falls.
- `EXEC_CYC`, 2400: execution wait for ordinary instructions and data writes (50 µs).
- `CLEAR_CYC`, 96000: execution wait for clear/return-home (2 ms).
- `POWERUP_CYC`, 960000: wait after reset before the first init command (20 ms).

Ports:
- `clk`, input, 1: system clock; single clock domain.
- `reset`, input, 1: synchronous, active-high reset.
- `data_ready`, input, 1: upstream has a byte to send.
- `d_in`, input, 8: byte to send.
- `rs_in`, input, 1: 0 = instruction, 1 = data.
- `d`, output, 8: LCD data bus.
- `e`, output, 1: LCD enable strobe.
- `rs`, output, 1: LCD register select.
- `busy_flag`, output, 1: high while the block cannot accept a byte.

## Operation
- Reset values: `d`=0x00, `e`=0, `rs`=0, `busy_flag`=1. The state returns to POWERUP_WAIT and the init index is cleared.
- A single down-counter times every phase. Its width is `$clog2` of the largest parameter plus 1. On phase entry it loads N−1, and the phase ends when the counter reaches 0, so each phase lasts exactly N cycles.
- States:
  - POWERUP_WAIT: `POWERUP_CYC` cycles, then go to INIT_LOAD.
  - INIT_LOAD: 1 cycle. Latches init command[idx] with rs=0: idx0=0x38, idx1=0x0C, idx2=0x06, idx3=0x01. Then go to SETUP.
  - SETUP: `SETUP_CYC` cycles, `e`=0.
  - E_HIGH: `EPW_CYC` cycles, `e`=1.
  - HOLD: `HOLD_CYC` cycles, `e`=0.
  - EXEC_WAIT: wait is `CLEAR_CYC` if the latched rs=0 and d∈{0x01,0x02,0x03}; otherwise `EXEC_CYC`.
    - On exit during init with idx<3: increment idx and go to INIT_LOAD.
    - On exit after idx=3 or after a user write: go to IDLE.
  - IDLE: `busy_flag`=0. Acceptance is `data_ready && !busy_flag` at a rising edge. On acceptance, `d_in`/`rs_in` are latched into `d`/`rs` and the state goes to SETUP.
- `busy_flag`=1 in every state except IDLE.
- `data_ready`, `d_in` and `rs_in` are ignored when not in IDLE. Nothing is queued.
- `d`/`rs` hold their latched value through SETUP, E_HIGH, HOLD and EXEC_WAIT, and keep it in IDLE until the next acceptance.
- `rs`=1 writes always use `EXEC_CYC`, even for byte 0x01.
- Reset mid-operation, in any state: on the next edge all outputs take reset values, `e` drops immediately and the init sequence restarts from POWERUP_WAIT.

## Timing
- Acceptance edge k: at k+1, `busy_flag`=1, `d`/`rs` are valid and `e`=0.
- `e` rises at k+1+`SETUP_CYC` and falls at k+1+`SETUP_CYC`+`EPW_CYC`.
- `busy_flag` falls at k+1+`SETUP_CYC`+`EPW_CYC`+`HOLD_CYC`+exec.
- Upstream advances in the same cycle its byte is accepted, because `busy_flag` is still 0 on that edge. Its next byte is accepted on the first cycle `busy_flag` is 0 again, so back-to-back transfers have exactly one idle cycle between them.
- Init duration from reset deassertion to `busy_flag`=0 is POWERUP + 4×(1+SETUP+EPW+HOLD) + 3×EXEC + CLEAR.

## Test plan
Bench parameters: SETUP=2, EPW=3, HOLD=2, EXEC=5, CLEAR=10, POWERUP=8.
- Reset for 3 cycles, then release. During reset: `d`=0, `e`=0, `rs`=0, `busy_flag`=1. Exactly four `e` pulses, each 3 cycles, with `d`=0x38, 0x0C, 0x06, 0x01 and `rs`=0. `busy_flag` falls 8+4×8+15+10=65 cycles after release.
- In IDLE, pulse `data_ready`=1 with `rs_in`=1, `d_in`=0x41. Next cycle `busy_flag`=1 and `d`=0x41, `rs`=1. `e` is high on cycles k+3..k+5. `busy_flag` returns to 0 at k+13, with `d`/`rs` stable throughout.
- Instruction 0x01 (rs=0): busy lasts 17 cycles. Same for 0x02.
- Data 0x01 (rs=1): busy lasts 12 cycles.
- Hold `data_ready`=1 continuously, changing `d_in` 0x41→0x42 on the acceptance edge. Exactly one `e` pulse per byte, in order. `d_in` toggles during busy do not change `d`.
- Assert `reset` while `e`=1. Next edge: `e`=0, `d`=0x00, `busy_flag`=1. Full init replays, and `busy_flag` falls 65 cycles after release.

Source files
------------

// File: rtl/lcd_bus_driver.sv
// ----------------------------------------------------------------------------
// lcd_bus_driver
//
// HD44780-style parallel bus engine. After reset it runs the power-on
// initialisation sequence (function set, display on, entry mode, clear) on its
// own, then accepts one byte at a time (instruction or character) and drives
// the RS/D/E waveform. busy_flag stays high for the full execution time of each
// instruction so the upstream controller never has to poll the display.
//
// Ports:
//   clk         system clock, single domain
//   reset       synchronous, active-high reset
//   data_ready  upstream has a byte to send (sampled only while idle)
//   d_in        byte to send
//   rs_in       0 = instruction, 1 = data
//   d           LCD data bus
//   e           LCD enable strobe
//   rs          LCD register select
//   busy_flag   high while the block cannot accept a byte
// ----------------------------------------------------------------------------

module lcd_bus_driver #(
    parameter int unsigned SETUP_CYC   = 4,
    parameter int unsigned EPW_CYC     = 16,
    parameter int unsigned HOLD_CYC    = 4,
    parameter int unsigned EXEC_CYC    = 2400,
    parameter int unsigned CLEAR_CYC   = 96000,
    parameter int unsigned POWERUP_CYC = 960000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_ready,
    input  logic [7:0] d_in,
    input  logic       rs_in,
    output logic [7:0] d,
    output logic       e,
    output logic       rs,
    output logic       busy_flag
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MaxCyc = max2(max2(max2(SETUP_CYC, EPW_CYC), max2(HOLD_CYC, EXEC_CYC)),
                                          max2(CLEAR_CYC, POWERUP_CYC));
    localparam int unsigned CntW = $clog2(MaxCyc) + 1;

    // Phase load values: a phase of N cycles loads N-1 and ends on zero.
    localparam logic [CntW-1:0] SetupLd   = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] EpwLd     = CntW'(EPW_CYC - 1);
    localparam logic [CntW-1:0] HoldLd    = CntW'(HOLD_CYC - 1);
    localparam logic [CntW-1:0] ExecLd    = CntW'(EXEC_CYC - 1);
    localparam logic [CntW-1:0] ClearLd   = CntW'(CLEAR_CYC - 1);
    localparam logic [CntW-1:0] PowerupLd = CntW'(POWERUP_CYC - 1);

    localparam logic [2:0] StPowerupWait = 3'd0;
    localparam logic [2:0] StInitLoad    = 3'd1;
    localparam logic [2:0] StSetup       = 3'd2;
    localparam logic [2:0] StEHigh       = 3'd3;
    localparam logic [2:0] StHold        = 3'd4;
    localparam logic [2:0] StExecWait    = 3'd5;
    localparam logic [2:0] StIdle        = 3'd6;

    // Power-on init: 8-bit/2-line, display on, increment, clear.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = 8'h38;
            2'd1:    cmd = 8'h0C;
            2'd2:    cmd = 8'h06;
            2'd3:    cmd = 8'h01;
            default: cmd = 8'h00;
        endcase
        return cmd;
    endfunction

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      d_q, d_d;
    logic            rs_q, rs_d;
    logic            e_q, e_d;
    logic            busy_q, busy_d;
    logic [1:0]      idx_q, idx_d;
    logic            init_done_q, init_done_d;

    logic            cnt_zero;
    logic            slow_cmd;

    assign cnt_zero = (cnt_q == '0);

    // Clear display (0x01) and return home (0x02/0x03) need the long wait;
    // data writes never do, whatever the byte value.
    assign slow_cmd = !rs_q && ((d_q == 8'h01) || (d_q == 8'h02) || (d_q == 8'h03));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_zero ? cnt_q : (cnt_q - CntW'(1));
        d_d         = d_q;
        rs_d        = rs_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;

        case (state_q)
            StPowerupWait: begin
                if (cnt_zero) begin
                    state_d = StInitLoad;
                end
            end

            StInitLoad: begin
                d_d     = init_cmd(idx_q);
                rs_d    = 1'b0;
                state_d = StSetup;
                cnt_d   = SetupLd;
            end

            StSetup: begin
                if (cnt_zero) begin
                    state_d = StEHigh;
                    cnt_d   = EpwLd;
                end
            end

            StEHigh: begin
                if (cnt_zero) begin
                    state_d = StHold;
                    cnt_d   = HoldLd;
                end
            end

            StHold: begin
                if (cnt_zero) begin
                    state_d = StExecWait;
                    cnt_d   = slow_cmd ? ClearLd : ExecLd;
                end
            end

            StExecWait: begin
                if (cnt_zero) begin
                    if (!init_done_q && (idx_q != 2'd3)) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = StInitLoad;
                    end else begin
                        init_done_d = 1'b1;
                        state_d     = StIdle;
                    end
                end
            end

            StIdle: begin
                if (data_ready && !busy_q) begin
                    d_d     = d_in;
                    rs_d    = rs_in;
                    state_d = StSetup;
                    cnt_d   = SetupLd;
                end
            end

            default: begin
                state_d = StPowerupWait;
                cnt_d   = PowerupLd;
            end
        endcase

        // Strobe and busy are registered from the next state so the pins
        // never see decode glitches.
        e_d    = (state_d == StEHigh);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StPowerupWait;
            cnt_q       <= PowerupLd;
            d_q         <= 8'h00;
            rs_q        <= 1'b0;
            e_q         <= 1'b0;
            busy_q      <= 1'b1;
            idx_q       <= 2'd0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            d_q         <= d_d;
            rs_q        <= rs_d;
            e_q         <= e_d;
            busy_q      <= busy_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
        end
    end

    assign d         = d_q;
    assign rs        = rs_q;
    assign e         = e_q;
    assign busy_flag = busy_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// ----------------------------------------------------------------------------
// tb_lcd_bus_driver
//
// Bench for lcd_bus_driver with short cycle counts. Every byte expected on the
// bus is pushed to a scoreboard queue when stimulus is driven; a monitor pops
// and compares each completed E pulse (byte, RS, width, stability).
// ----------------------------------------------------------------------------

module tb_lcd_bus_driver;

    localparam int SETUP   = 2;
    localparam int EPW     = 3;
    localparam int HOLD    = 2;
    localparam int EXEC    = 5;
    localparam int CLEAR   = 10;
    localparam int POWERUP = 8;

    localparam int INIT_CYC = POWERUP + 4 * (1 + SETUP + EPW + HOLD) + 3 * EXEC + CLEAR;
    localparam int DATA_BUSY = SETUP + EPW + HOLD + EXEC;
    localparam int SLOW_BUSY = SETUP + EPW + HOLD + CLEAR;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic       rs_in = 1'b0;
    logic [7:0] d;
    logic       e;
    logic       rs;
    logic       busy_flag;

    always #5 clk = ~clk;

    lcd_bus_driver #(
        .SETUP_CYC  (SETUP),
        .EPW_CYC    (EPW),
        .HOLD_CYC   (HOLD),
        .EXEC_CYC   (EXEC),
        .CLEAR_CYC  (CLEAR),
        .POWERUP_CYC(POWERUP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_ready(data_ready),
        .d_in      (d_in),
        .rs_in     (rs_in),
        .d         (d),
        .e         (e),
        .rs        (rs),
        .busy_flag (busy_flag)
    );

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];     // {rs, d}
    int         pulses = 0;
    bit         ignore_pulse = 1'b0;

    // ---------------- E pulse monitor / scoreboard ----------------
    bit         e_prev = 1'b0;
    int         plen = 0;
    logic [7:0] pd = 8'h00;
    logic       pr = 1'b0;
    bit         pstable = 1'b1;
    logic [8:0] mon_exp;

    always @(negedge clk) begin
        if (e === 1'b1 && !e_prev) begin
            plen    = 1;
            pd      = d;
            pr      = rs;
            pstable = 1'b1;
        end else if (e === 1'b1) begin
            plen++;
            if (d !== pd || rs !== pr) pstable = 1'b0;
        end else if (e_prev && !ignore_pulse) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got d=%h rs=%b, required no pulse", pd, pr);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({pr, pd} !== mon_exp) begin
                    errors++;
                    $display("FAIL pulse_byte: got rs=%b d=%h, required rs=%b d=%h",
                             pr, pd, mon_exp[8], mon_exp[7:0]);
                end
                checks++;
                if (plen != EPW) begin
                    errors++;
                    $display("FAIL pulse_width: got %0d, required %0d", plen, EPW);
                end
                checks++;
                if (!pstable) begin
                    errors++;
                    $display("FAIL pulse_stable: d/rs changed while e was high (d=%h)", pd);
                end
            end
        end
        e_prev = (e === 1'b1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
    endtask

    // Called at a negedge with reset just released; returns cycles to busy low.
    task automatic count_release(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_flag !== 1'b0 && n < 1000);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_flag !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Called at a negedge with busy low. Returns the number of busy cycles and
    // whether e/d/rs followed the expected waveform throughout.
    task automatic send_byte(input logic r, input logic [7:0] b, output int n,
                             output bit wave_ok);
        data_ready = 1'b1;
        rs_in      = r;
        d_in       = b;
        exp_q.push_back({r, b});
        n       = 0;
        wave_ok = 1'b1;
        do begin
            @(negedge clk);
            data_ready = 1'b0;
            if (busy_flag === 1'b1) begin
                n++;
                if (e !== ((n > SETUP) && (n <= SETUP + EPW))) wave_ok = 1'b0;
                if (d !== b || rs !== r) wave_ok = 1'b0;
                d_in  = 8'($urandom);
                rs_in = 1'($urandom);
            end
        end while (busy_flag === 1'b1 && n < 1000);
        d_in  = 8'h00;
        rs_in = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        int p0;
        reset      = 1'b1;
        data_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({d, e, rs, busy_flag} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL reset_values: got d=%h e=%b rs=%b busy=%b, required 00 0 0 1",
                         d, e, rs, busy_flag);
            end
        end
        p0 = pulses;
        push_init();
        reset = 1'b0;
        count_release(n);
        checks++;
        if (n != INIT_CYC) begin
            errors++;
            $display("FAIL init_duration: got %0d, required %0d", n, INIT_CYC);
        end
        checks++;
        if (pulses - p0 != 4) begin
            errors++;
            $display("FAIL init_pulse_count: got %0d, required 4", pulses - p0);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL init_queue_empty: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_data_write();
        int n;
        bit ok;
        wait_idle();
        send_byte(1'b1, 8'h41, n, ok);
        checks++;
        if (n != DATA_BUSY) begin
            errors++;
            $display("FAIL data41_busy_len: got %0d, required %0d", n, DATA_BUSY);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL data41_waveform: got bad e/d/rs sequence, required e on %0d..%0d",
                     SETUP + 1, SETUP + EPW);
        end
        checks++;
        if ({rs, d} !== {1'b1, 8'h41}) begin
            errors++;
            $display("FAIL idle_hold: got rs=%b d=%h, required 1 41", rs, d);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL data41_queue: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_exec_times();
        logic [7:0] bytes [6] = '{8'h01, 8'h02, 8'h03, 8'h01, 8'h04, 8'h00};
        logic       rsv   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int         lens  [6] = '{SLOW_BUSY, SLOW_BUSY, SLOW_BUSY, DATA_BUSY, DATA_BUSY, DATA_BUSY};
        int n;
        bit ok;
        for (int i = 0; i < 6; i++) begin
            wait_idle();
            send_byte(rsv[i], bytes[i], n, ok);
            checks++;
            if (n != lens[i]) begin
                errors++;
                $display("FAIL exec_len rs=%b d=%h: got %0d, required %0d",
                         rsv[i], bytes[i], n, lens[i]);
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL exec_waveform rs=%b d=%h: got bad e/d/rs sequence, required clean",
                         rsv[i], bytes[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int p0;
        wait_idle();
        p0         = pulses;
        data_ready = 1'b1;
        rs_in      = 1'b1;
        d_in       = 8'h41;
        exp_q.push_back({1'b1, 8'h41});
        @(negedge clk);
        d_in = 8'h42;
        exp_q.push_back({1'b1, 8'h42});
        checks++;
        if ({busy_flag, rs, d} !== {1'b1, 1'b1, 8'h41}) begin
            errors++;
            $display("FAIL b2b_first: got busy=%b rs=%b d=%h, required 1 1 41", busy_flag, rs, d);
        end
        n = 0;
        while (busy_flag === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != DATA_BUSY) begin
            errors++;
            $display("FAIL b2b_first_busy: got %0d, required %0d", n, DATA_BUSY);
        end
        @(negedge clk);
        data_ready = 1'b0;
        checks++;
        if ({busy_flag, rs, d} !== {1'b1, 1'b1, 8'h42}) begin
            errors++;
            $display("FAIL b2b_second: got busy=%b rs=%b d=%h, required 1 1 42 after one idle",
                     busy_flag, rs, d);
        end
        wait_idle();
        checks++;
        if (pulses - p0 != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d pulses %0d pending, required 2 pulses 0 pending",
                     pulses - p0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int p0;
        wait_idle();
        data_ready = 1'b1;
        rs_in      = 1'b1;
        d_in       = 8'h55;
        exp_q.push_back({1'b1, 8'h55});
        @(negedge clk);
        data_ready = 1'b0;
        n = 0;
        while (e !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL mid_e_seen: got e=%b, required 1 within 50 cycles", e);
        end
        ignore_pulse = 1'b1;
        reset        = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if ({d, e, rs, busy_flag} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset_values: got d=%h e=%b rs=%b busy=%b, required 00 0 0 1",
                     d, e, rs, busy_flag);
        end
        @(negedge clk);
        ignore_pulse = 1'b0;
        p0           = pulses;
        push_init();
        reset = 1'b0;
        count_release(n);
        checks++;
        if (n != INIT_CYC) begin
            errors++;
            $display("FAIL reinit_duration: got %0d, required %0d", n, INIT_CYC);
        end
        checks++;
        if (pulses - p0 != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reinit_pulses: got %0d pulses %0d pending, required 4 pulses 0 pending",
                     pulses - p0, exp_q.size());
        end
    endtask

    task automatic test_after_reinit();
        int n;
        bit ok;
        wait_idle();
        send_byte(1'b1, 8'h7A, n, ok);
        checks++;
        if (n != DATA_BUSY || !ok) begin
            errors++;
            $display("FAIL post_reinit_write: got busy %0d ok=%b, required %0d ok=1",
                     n, ok, DATA_BUSY);
        end
    endtask

    initial begin
        test_reset();
        test_data_write();
        test_exec_times();
        test_back_to_back();
        test_reset_mid();
        test_after_reinit();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
